// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
//   AHB-Lite SRAM slave placed directly behind one interconnect slave port.
//   Byte-addressable local memory of 2**SLAVE_MEMORY_SIZE bytes with a fixed
//   number of wait states per OKAY data phase and the two-cycle ERROR reply
//   for oversize or misaligned transfers.
//
// Ports
//   hclk, hreset          clock and synchronous active-high reset
//   hselx, haddr, htrans,
//   hwrite, hsize         address phase from the interconnect
//   hburst, hprot,
//   hmastlock             accepted but unused
//   hwdata, hwstrb        write data / byte strobes, valid in the data phase
//   hready                bus-level ready (previous data phase completing)
//   hreadyout, hresp,
//   hrdata                slave response

module ahb_sram_slave #(
  parameter int ADDR_WIDTH        = 32,
  parameter int DATA_WIDTH        = 32,
  parameter int SLAVE_MEMORY_SIZE = 10,
  parameter int WAIT_STATES       = 0
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    hselx,
  input  logic [ADDR_WIDTH-1:0]   haddr,
  input  logic [1:0]              htrans,
  input  logic                    hwrite,
  input  logic [2:0]              hsize,
  input  logic [2:0]              hburst,
  input  logic [3:0]              hprot,
  input  logic                    hmastlock,
  input  logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH/8-1:0] hwstrb,
  input  logic                    hready,
  output logic                    hreadyout,
  output logic [1:0]              hresp,
  output logic [DATA_WIDTH-1:0]   hrdata
);

  localparam int NB     = DATA_WIDTH / 8;
  localparam int BYTE_W = $clog2(NB);
  localparam int IDX_W  = SLAVE_MEMORY_SIZE - BYTE_W;
  localparam int DEPTH  = 1 << IDX_W;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  // Oversize transfers and addresses not aligned to the transfer size.
  function automatic logic is_error(input logic [BYTE_W-1:0] off,
                                    input logic [2:0]        size);
    logic bad;
    bad = (size > 3'(BYTE_W));
    for (int i = 0; i < BYTE_W; i++) begin
      if ((i < int'(size)) && off[i]) bad = 1'b1;
    end
    return bad;
  endfunction

  // Byte lanes covered by a transfer of 2**size bytes starting at lane off.
  function automatic logic [NB-1:0] lane_mask(input logic [BYTE_W-1:0] off,
                                              input logic [2:0]        size);
    logic [NB-1:0] m;
    int            lo;
    int            hi;
    lo = int'(off);
    hi = lo + (1 << size);
    for (int i = 0; i < NB; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic                  write_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic [NB-1:0]         mask_p1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [BYTE_W-1:0]     addr_off;
  logic [IDX_W-1:0]      addr_idx;
  logic                  completing;
  logic                  can_accept;
  logic                  accept;
  logic                  addr_err;
  logic                  commit;

  // Upper address bits select the slave in the interconnect; the rest of
  // these inputs carry no information this memory needs.
  logic                  unused_inputs;
  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0], haddr};

  assign addr_off   = haddr[BYTE_W-1:0];
  assign addr_idx   = haddr[SLAVE_MEMORY_SIZE-1:BYTE_W];
  assign completing = (state == ST_DATA) && (wait_cnt == 4'd0);
  // A new address phase can only land on a cycle where our own data phase
  // (if any) is completing; ERR1 and wait cycles hold hready low anyway.
  assign can_accept = (state == ST_IDLE) || (state == ST_ERR2) || completing;
  assign accept     = can_accept && hselx && hready && htrans[1];
  assign addr_err   = is_error(addr_off, hsize);
  assign commit     = completing && write_p1;

  // Address phase -> data phase (control)
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      write_p1 <= 1'b0;
    end else if (can_accept) begin
      if (accept) begin
        state    <= addr_err ? ST_ERR1 : ST_DATA;
        wait_cnt <= addr_err ? 4'd0 : 4'(WAIT_STATES);
        write_p1 <= hwrite && !addr_err;
      end else begin
        state    <= ST_IDLE;
        wait_cnt <= 4'd0;
        write_p1 <= 1'b0;
      end
    end else if (state == ST_ERR1) begin
      state <= ST_ERR2;
    end else begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Address phase -> data phase (datapath). Offset and size are folded into
  // the lane mask at capture time since nothing else in the data phase uses them.
  always_ff @(posedge hclk) begin
    if (accept) begin
      idx_p1  <= addr_idx;
      mask_p1 <= lane_mask(addr_off, hsize);
    end
  end

  // Data phase end: write commit; a reset on this edge aborts the write.
  always_ff @(posedge hclk) begin
    if (commit && !hreset) begin
      for (int i = 0; i < NB; i++) begin
        if (hwstrb[i] && mask_p1[i]) mem[idx_p1][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  assign hreadyout = !((state == ST_ERR1) || ((state == ST_DATA) && (wait_cnt != 4'd0)));
  assign hresp     = ((state == ST_ERR1) || (state == ST_ERR2)) ? 2'b01 : 2'b00;
  assign hrdata    = ((state == ST_DATA) && !write_p1) ? mem[idx_p1] : '0;

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite SRAM slave that sits directly downstream of the AHB interconnect; one instance per slave port.
- Consumes the per-slave address/control/data bus that the interconnect drives and returns hreadyout/hresp/hrdata.
- Implements a byte-addressable local memory with programmable wait states and the two-cycle AHB ERROR response.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width; 32 or 64 only.
- SLAVE_MEMORY_SIZE, 10, log2 of memory size in bytes. Local offset is haddr[SLAVE_MEMORY_SIZE-1:0]; upper bits are ignored.
- WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  bus clock, all state on rising edge.
- hreset  in  1  synchronous reset, active-high.
- hselx  in  1  slave select from interconnect.
- haddr  in  ADDR_WIDTH  transfer address.
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size, log2 bytes.
- hburst  in  3  burst type; informational only.
- hprot  in  4  protection; ignored.
- hmastlock  in  1  locked transfer; ignored.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hwstrb  in  DATA_WIDTH/8  write byte strobes, valid in the data phase.
- hready  in  1  bus-level ready; 1 = previous data phase completing.
- hreadyout  out  1  slave ready.
- hresp  out  2  00 OKAY, 01 ERROR.
- hrdata  out  DATA_WIDTH  read data.

Behaviour:
- Reset (hreset=1 at a hclk edge):
  - State returns to IDLE. hreadyout=1, hresp=00, hrdata=0.
  - Wait counter is cleared and any captured address phase is discarded; an in-flight write is not committed.
  - Memory contents are not cleared.
- Accept: an address phase is accepted at a hclk edge when hselx & hready & htrans[1].
  - On accept, capture the word index, byte offset, hsize and hwrite.
  - BUSY, IDLE, or an unselected cycle is not accepted; the slave returns to or stays in IDLE (OKAY, zero wait).
- Error check at accept; the transfer is an error if either holds:
  - hsize > log2(DATA_WIDTH/8);
  - haddr is not aligned to 2^hsize.
- State machine:
  - IDLE: hreadyout=1, hresp=00.
    - Accept OK -> DATA, wait counter := WAIT_STATES.
    - Accept error -> ERR1.
  - DATA, counter > 0: hreadyout=0, hresp=00; counter decrements each cycle.
  - DATA, counter = 0: hreadyout=1, hresp=00; this is the completing cycle.
    - If a new accept occurs in the same cycle (pipelined back-to-back), go to DATA or ERR1 per the new transfer and reload the counter.
    - Otherwise go to IDLE.
  - ERR1: hreadyout=0, hresp=01. Always goes to ERR2; no accept is possible because hready is low.
  - ERR2: hreadyout=1, hresp=01. Accept rules are the same as the IDLE/DATA completion.
- Write commit: occurs only at the completing edge of a DATA write phase (hreadyout=1, no error).
  - Byte lane i is written iff hwstrb[i] & lane_mask[i].
  - lane_mask = the lanes covered by hsize at the captured byte offset.
  - Error transfers never write memory.
- Read data:
  - hrdata = memory word at the captured index, driven throughout the DATA read phase and valid when hreadyout=1.
  - hrdata = 0 in IDLE, ERR1, ERR2 and in write phases.
  - Writes commit at the edge that ends their data phase, so a read whose data phase directly follows a write to the same word returns the new data.
- Wrap: the offset is taken modulo 2^SLAVE_MEMORY_SIZE; no out-of-range error is raised.
- hready low while in IDLE (another slave stalling the bus): no accept, state held.
- Reset mid-wait or mid-error: the state goes to IDLE immediately; the next accept behaves as after power-up.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x10 with hwstrb=4'hF, then back-to-back read of 0x10 -> read data phase shows hreadyout=1, hresp=00, hrdata=0xDEADBEEF with zero wait.
- WAIT_STATES=2: single write followed by a read -> hreadyout reads 0,0,1 in each data phase; hrdata is valid only on the third cycle.
- Byte write: 0x55 to 0x13 with hsize=0, hwstrb=4'h8 over an existing 0x11223344 -> a subsequent word read returns 0x55223344. Repeat with hwstrb=4'hF: only lane 3 changes.
- Misaligned halfword write at 0x11 -> ERR1 (hreadyout=0, hresp=01), then ERR2 (hreadyout=1, hresp=01). Memory is unchanged and the next NONSEQ accepted in ERR2 completes with OKAY.
- Wrap: SLAVE_MEMORY_SIZE=10, write 0xA5A5A5A5 at 0x400 -> a read at 0x000 returns 0xA5A5A5A5. BUSY between transfers -> OKAY with zero wait.
- Reset asserted during the 2nd wait cycle of a write -> next cycle hreadyout=1, hresp=00, hrdata=0, and the target word is unchanged.
